// File: rtl/ramio_arbiter.sv
// Two-port round-robin arbiter in front of a single RAMIO slave.
// Port 0 is instruction fetch and port 1 is data access. One transaction is
// in flight at a time. Every transaction ends with exactly one done pulse,
// or it is aborted by the WAIT-state timeout.
module ramio_arbiter #(
    parameter int ADDRESS_BITWIDTH = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int TIMEOUT_CYCLES   = 1023
) (
    input  logic                        clk,
    input  logic                        rst,
    // requester 0 (instruction fetch)
    input  logic                        s0_req,
    input  logic [1:0]                  s0_write_type,
    input  logic [2:0]                  s0_read_type,
    input  logic [ADDRESS_BITWIDTH-1:0] s0_address,
    input  logic [DATA_WIDTH-1:0]       s0_data_in,
    output logic [DATA_WIDTH-1:0]       s0_data_out,
    output logic                        s0_done,
    // requester 1 (data access)
    input  logic                        s1_req,
    input  logic [1:0]                  s1_write_type,
    input  logic [2:0]                  s1_read_type,
    input  logic [ADDRESS_BITWIDTH-1:0] s1_address,
    input  logic [DATA_WIDTH-1:0]       s1_data_in,
    output logic [DATA_WIDTH-1:0]       s1_data_out,
    output logic                        s1_done,
    // downstream RAMIO
    output logic                        m_enable,
    output logic [1:0]                  m_write_type,
    output logic [2:0]                  m_read_type,
    output logic [ADDRESS_BITWIDTH-1:0] m_address,
    output logic [DATA_WIDTH-1:0]       m_data_in,
    input  logic [DATA_WIDTH-1:0]       m_data_out,
    input  logic                        m_data_out_ready,
    input  logic                        m_busy,
    output logic                        timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                      r_state;
    logic                        r_last_grant;
    logic                        r_port;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_m_enable;
    logic [1:0]                  r_m_write_type;
    logic [2:0]                  r_m_read_type;
    logic [ADDRESS_BITWIDTH-1:0] r_m_address;
    logic [DATA_WIDTH-1:0]       r_m_data_in;
    logic                        r_s0_done;
    logic                        r_s1_done;
    logic [DATA_WIDTH-1:0]       r_s0_data_out;
    logic [DATA_WIDTH-1:0]       r_s1_data_out;
    logic                        r_timeout_err;

    logic                        w_grant_valid;
    logic                        w_grant_port;
    logic [1:0]                  w_sel_write_type;
    logic [2:0]                  w_sel_read_type;
    logic [ADDRESS_BITWIDTH-1:0] w_sel_address;
    logic [DATA_WIDTH-1:0]       w_sel_data_in;
    logic                        w_is_write;
    logic                        w_complete;
    logic [CNT_W-1:0]            w_cnt_next;
    logic                        w_expired;
    logic [DATA_WIDTH-1:0]       w_result;

    // On a tie, the port that was not served last wins. A lone requester always wins.
    assign w_grant_valid    = (s0_req | s1_req) & ~m_busy;
    assign w_grant_port     = (s0_req & s1_req) ? ~r_last_grant : s1_req;
    assign w_sel_write_type = w_grant_port ? s1_write_type : s0_write_type;
    assign w_sel_read_type  = w_grant_port ? s1_read_type  : s0_read_type;
    assign w_sel_address    = w_grant_port ? s1_address    : s0_address;
    assign w_sel_data_in    = w_grant_port ? s1_data_in    : s0_data_in;

    // A write (even one that also carries a read type) completes on !busy alone.
    assign w_is_write = (r_m_write_type != 2'b00);
    assign w_complete = ~m_busy & (w_is_write | m_data_out_ready);
    assign w_cnt_next = r_cnt + 1'b1;
    assign w_expired  = (w_cnt_next == CNT_MAX);
    assign w_result   = w_is_write ? '0 : m_data_out;

    // Arbitration FSM. All outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_last_grant   <= 1'b1;
            r_port         <= 1'b0;
            r_cnt          <= '0;
            r_m_enable     <= 1'b0;
            r_m_write_type <= 2'b00;
            r_m_read_type  <= 3'b000;
            r_m_address    <= '0;
            r_m_data_in    <= '0;
            r_s0_done      <= 1'b0;
            r_s1_done      <= 1'b0;
            r_s0_data_out  <= '0;
            r_s1_data_out  <= '0;
            r_timeout_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_m_enable     <= 1'b0;
                    r_m_write_type <= 2'b00;
                    r_m_read_type  <= 3'b000;
                    if (w_grant_valid) begin
                        r_port         <= w_grant_port;
                        r_last_grant   <= w_grant_port;
                        r_m_enable     <= 1'b1;
                        r_m_write_type <= w_sel_write_type;
                        r_m_read_type  <= w_sel_read_type;
                        r_m_address    <= w_sel_address;
                        r_m_data_in    <= w_sel_data_in;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion wins over an expiry in the same cycle.
                    if (w_complete || w_expired) begin
                        r_m_enable     <= 1'b0;
                        r_m_write_type <= 2'b00;
                        r_m_read_type  <= 3'b000;
                        r_timeout_err  <= ~w_complete;
                        if (r_port) begin
                            r_s1_done     <= 1'b1;
                            r_s1_data_out <= w_complete ? w_result : '0;
                        end else begin
                            r_s0_done     <= 1'b1;
                            r_s0_data_out <= w_complete ? w_result : '0;
                        end
                        r_state <= S_DONE;
                    end
                    if (!w_complete) begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_DONE: begin
                    r_s0_done     <= 1'b0;
                    r_s1_done     <= 1'b0;
                    r_s0_data_out <= '0;
                    r_s1_data_out <= '0;
                    r_timeout_err <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_enable     = r_m_enable;
    assign m_write_type = r_m_write_type;
    assign m_read_type  = r_m_read_type;
    assign m_address    = r_m_address;
    assign m_data_in    = r_m_data_in;
    assign s0_done      = r_s0_done;
    assign s1_done      = r_s1_done;
    assign s0_data_out  = r_s0_data_out;
    assign s1_data_out  = r_s1_data_out;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_ramio_arbiter.sv
// Directed bench for ramio_arbiter. The bench drives inputs and samples
// outputs on the falling clock edge.
module tb_ramio_arbiter;

    logic        clk;
    logic        rst;
    logic        s0_req, s1_req;
    logic [1:0]  s0_write_type, s1_write_type;
    logic [2:0]  s0_read_type, s1_read_type;
    logic [31:0] s0_address, s1_address, s0_data_in, s1_data_in;
    logic [31:0] s0_data_out, s1_data_out;
    logic        s0_done, s1_done;
    logic        m_enable;
    logic [1:0]  m_write_type;
    logic [2:0]  m_read_type;
    logic [31:0] m_address, m_data_in, m_data_out;
    logic        m_data_out_ready, m_busy;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    ramio_arbiter #(
        .ADDRESS_BITWIDTH(32),
        .DATA_WIDTH      (32),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s0_req          (s0_req),
        .s0_write_type   (s0_write_type),
        .s0_read_type    (s0_read_type),
        .s0_address      (s0_address),
        .s0_data_in      (s0_data_in),
        .s0_data_out     (s0_data_out),
        .s0_done         (s0_done),
        .s1_req          (s1_req),
        .s1_write_type   (s1_write_type),
        .s1_read_type    (s1_read_type),
        .s1_address      (s1_address),
        .s1_data_in      (s1_data_in),
        .s1_data_out     (s1_data_out),
        .s1_done         (s1_done),
        .m_enable        (m_enable),
        .m_write_type    (m_write_type),
        .m_read_type     (m_read_type),
        .m_address       (m_address),
        .m_data_in       (m_data_in),
        .m_data_out      (m_data_out),
        .m_data_out_ready(m_data_out_ready),
        .m_busy          (m_busy),
        .timeout_err     (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        total++; if (m_enable !== 1'b0) begin bad++; $display("FAIL rst_m_enable got=%0h exp=0", m_enable); end
        total++; if ({m_write_type, m_read_type} !== 5'd0) begin bad++; $display("FAIL rst_m_types got=%0h exp=0", {m_write_type, m_read_type}); end
        total++; if ({m_address, m_data_in} !== 64'd0) begin bad++; $display("FAIL rst_m_addr_data got=%0h exp=0", {m_address, m_data_in}); end
        total++; if ({s0_done, s1_done, timeout_err} !== 3'd0) begin bad++; $display("FAIL rst_pulses got=%0h exp=0", {s0_done, s1_done, timeout_err}); end
        total++; if ({s0_data_out, s1_data_out} !== 64'd0) begin bad++; $display("FAIL rst_data_out got=%0h exp=0", {s0_data_out, s1_data_out}); end
        rst = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_single_read();
        s0_req = 1'b1; s0_address = 32'h100; s0_read_type = 3'b111; s0_write_type = 2'b00;
        m_busy = 1'b0; m_data_out_ready = 1'b1; m_data_out = 32'hDEADBEEF;
        @(negedge clk); // ISSUE (N+1)
        total++; if (m_enable !== 1'b1) begin bad++; $display("FAIL rd_issue_enable got=%0h exp=1", m_enable); end
        total++; if (m_address !== 32'h100) begin bad++; $display("FAIL rd_issue_addr got=%0h exp=100", m_address); end
        total++; if (m_read_type !== 3'b111) begin bad++; $display("FAIL rd_issue_rtype got=%0h exp=7", m_read_type); end
        @(negedge clk); // WAIT (N+2)
        total++; if (s0_done !== 1'b0) begin bad++; $display("FAIL rd_early_done got=%0h exp=0", s0_done); end
        @(negedge clk); // DONE (N+3)
        total++; if (s0_done !== 1'b1) begin bad++; $display("FAIL rd_done got=%0h exp=1", s0_done); end
        total++; if (s0_data_out !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%0h exp=deadbeef", s0_data_out); end
        total++; if ({s1_done, timeout_err, m_enable} !== 3'd0) begin bad++; $display("FAIL rd_done_others got=%0h exp=0", {s1_done, timeout_err, m_enable}); end
        s0_req = 1'b0;
        @(negedge clk); // IDLE
        total++; if ({s0_done, s0_data_out} !== 33'd0) begin bad++; $display("FAIL rd_after_done got=%0h exp=0", {s0_done, s0_data_out}); end
        total++; if (m_read_type !== 3'b000) begin bad++; $display("FAIL rd_idle_rtype got=%0h exp=0", m_read_type); end
        $display("txn single read port0 addr=100 data=%0h", s0_data_out);
    endtask

    task automatic test_busy_at_request();
        m_busy = 1'b1; m_data_out_ready = 1'b1; m_data_out = 32'h12345678;
        s0_req = 1'b1; s0_address = 32'h200; s0_read_type = 3'b011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (m_enable !== 1'b0) begin bad++; $display("FAIL busy_hold_enable cyc=%0d got=%0h exp=0", i, m_enable); end
        end
        m_busy = 1'b0;
        @(negedge clk);
        total++; if (m_enable !== 1'b1) begin bad++; $display("FAIL busy_release_enable got=%0h exp=1", m_enable); end
        @(negedge clk);
        @(negedge clk);
        total++; if (s0_done !== 1'b1 || s0_data_out !== 32'h12345678) begin bad++; $display("FAIL busy_done got=%0h/%0h exp=1/12345678", s0_done, s0_data_out); end
        s0_req = 1'b0;
        @(negedge clk);
        $display("txn busy-at-request port0 addr=200");
    endtask

    task automatic test_write();
        s1_req = 1'b1; s1_write_type = 2'b01; s1_read_type = 3'b000;
        s1_address = 32'h7; s1_data_in = 32'h41;
        m_busy = 1'b0; m_data_out_ready = 1'b0; m_data_out = 32'h0;
        @(negedge clk); // ISSUE
        total++; if (m_enable !== 1'b1 || m_write_type !== 2'b01) begin bad++; $display("FAIL wr_issue got=%0h/%0h exp=1/1", m_enable, m_write_type); end
        total++; if (m_address !== 32'h7 || m_data_in !== 32'h41) begin bad++; $display("FAIL wr_issue_fields got=%0h/%0h exp=7/41", m_address, m_data_in); end
        m_busy = 1'b1;
        s1_req = 1'b0; // dropping req after grant must not abort
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (s1_done !== 1'b0) begin bad++; $display("FAIL wr_busy_done cyc=%0d got=%0h exp=0", i, s1_done); end
        end
        m_busy = 1'b0;
        @(negedge clk);
        total++; if (s1_done !== 1'b1) begin bad++; $display("FAIL wr_done got=%0h exp=1", s1_done); end
        total++; if (s1_data_out !== 32'h0 || s0_done !== 1'b0) begin bad++; $display("FAIL wr_done_data got=%0h/%0h exp=0/0", s1_data_out, s0_done); end
        @(negedge clk);
        total++; if (s1_done !== 1'b0) begin bad++; $display("FAIL wr_single_pulse got=%0h exp=0", s1_done); end
        $display("txn write port1 addr=7 data=41");
    endtask

    task automatic test_contention();
        int exp_port;
        int waited;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_busy = 1'b0; m_data_out_ready = 1'b1;
        s0_read_type = 3'b010; s1_read_type = 3'b010;
        s0_write_type = 2'b00; s1_write_type = 2'b00;
        s0_address = 32'h40; s1_address = 32'h80;
        m_data_out = 32'h1000;
        s0_req = 1'b1; s1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_port = k % 2;
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!(s0_done || s1_done) && waited < 10);
            total++; if (waited >= 10) begin bad++; $display("FAIL rr_timeout grant=%0d got=no_done exp=done", k); end
            total++;
            if ({s1_done, s0_done} !== ((exp_port == 0) ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL rr_order grant=%0d got=%0b exp_port=%0d", k, {s1_done, s0_done}, exp_port);
            end
            total++;
            if ((exp_port == 0 ? s0_data_out : s1_data_out) !== 32'h1000 + 32'(k) ||
                (exp_port == 0 ? s1_data_out : s0_data_out) !== 32'h0) begin
                bad++; $display("FAIL rr_data grant=%0d got=%0h/%0h exp=%0h", k, s0_data_out, s1_data_out, 32'h1000 + 32'(k));
            end
            $display("txn contention grant=%0d port=%0d", k, exp_port);
            m_data_out = 32'h1000 + 32'(k + 1);
        end
        s0_req = 1'b0; s1_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        int waited;
        s0_req = 1'b1; s0_address = 32'h300; s0_read_type = 3'b010;
        m_busy = 1'b0; m_data_out_ready = 1'b0;
        @(negedge clk); // ISSUE
        m_busy = 1'b1;
        @(negedge clk); // WAIT
        @(negedge clk); // WAIT
        rst = 1'b1;
        #1;
        total++; if ({m_enable, m_write_type, m_read_type} !== 6'd0) begin bad++; $display("FAIL rw_m_ctrl got=%0h exp=0", {m_enable, m_write_type, m_read_type}); end
        total++; if (m_address !== 32'h0) begin bad++; $display("FAIL rw_m_addr got=%0h exp=0", m_address); end
        @(negedge clk);
        rst = 1'b0; s0_req = 1'b0; m_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if ({s0_done, s1_done, m_enable} !== 3'd0) begin bad++; $display("FAIL rw_no_done cyc=%0d got=%0h exp=0", i, {s0_done, s1_done, m_enable}); end
        end
        s1_req = 1'b1; s1_address = 32'h44; s1_read_type = 3'b110; s1_write_type = 2'b00;
        m_data_out_ready = 1'b1; m_data_out = 32'hCAFE0001;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!s1_done && waited < 10);
        total++; if (s1_done !== 1'b1 || s1_data_out !== 32'hCAFE0001) begin bad++; $display("FAIL rw_next_txn got=%0h/%0h exp=1/cafe0001", s1_done, s1_data_out); end
        total++; if (waited !== 3) begin bad++; $display("FAIL rw_next_latency got=%0d exp=3", waited); end
        s1_req = 1'b0;
        @(negedge clk);
        $display("txn reset-in-wait then port1 read data=cafe0001");
    endtask

    task automatic test_timeout();
        int waited;
        s0_req = 1'b1; s0_address = 32'h500; s0_read_type = 3'b010;
        m_busy = 1'b0; m_data_out_ready = 1'b1; m_data_out = 32'hBADBAD00;
        @(negedge clk); // ISSUE
        m_busy = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
            if (!s0_done) begin
                total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_early_err cyc=%0d got=%0h exp=0", waited, timeout_err); end
            end
        end while (!s0_done && waited < 30);
        total++; if (s0_done !== 1'b1) begin bad++; $display("FAIL to_done got=%0h exp=1", s0_done); end
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err got=%0h exp=1", timeout_err); end
        total++; if (s0_data_out !== 32'h0) begin bad++; $display("FAIL to_data got=%0h exp=0", s0_data_out); end
        total++; if (waited < 9) begin bad++; $display("FAIL to_too_soon got=%0d exp>=9", waited); end
        s0_req = 1'b0; m_busy = 1'b0;
        @(negedge clk);
        total++; if ({timeout_err, s0_done, m_enable} !== 3'd0) begin bad++; $display("FAIL to_idle got=%0h exp=0", {timeout_err, s0_done, m_enable}); end
        $display("txn timeout port0 addr=500 cycles=%0d", waited);
    endtask

    initial begin
        rst = 1'b1;
        s0_req = 1'b0; s1_req = 1'b0;
        s0_write_type = 2'b00; s1_write_type = 2'b00;
        s0_read_type = 3'b000; s1_read_type = 3'b000;
        s0_address = 32'h0; s1_address = 32'h0;
        s0_data_in = 32'h0; s1_data_in = 32'h0;
        m_data_out = 32'h0; m_data_out_ready = 1'b0; m_busy = 1'b0;
        test_reset();
        test_single_read();
        test_busy_at_request();
        test_write();
        test_contention();
        test_reset_in_wait();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
